// File: rtl/cnn_layer_sequencer.sv
// Walks the CNN parameter header in the shared parameter RAM and emits one layer
// descriptor per layer (conv first, then dense) over a valid/ready handshake.
module cnn_layer_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_LAYERS = 10
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              readSignal,
    input  logic [DATA_W-1:0] ramDataOut,
    output logic              layerValid,
    input  logic              layerReady,
    output logic              layerIsConv,
    output logic [3:0]        layerIndex,
    output logic [DATA_W-1:0] layerCount,
    output logic [DATA_W-1:0] layerType,
    output logic [ADDR_W-1:0] paramBase,
    output logic [ADDR_W-1:0] biasBase,
    output logic [DATA_W-1:0] filterSize,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        IDLE, RD_HDR, RD_CONV, CALC, EMIT_CONV, CHECK, RD_DENSE, EMIT_DENSE, FINISH, ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_phase;
    logic [1:0]        r_word;
    logic [3:0]        r_index;
    logic              r_denseMode;
    logic [DATA_W-1:0] r_fs;
    logic [DATA_W-1:0] r_layers;
    logic [ADDR_W-1:0] r_denseOff;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_type;
    logic [ADDR_W-1:0] r_paramBase;
    logic [ADDR_W-1:0] r_biasBase;
    logic              r_isConv;
    logic              r_error;

    logic              w_reading;
    logic              w_lastWord;
    logic              w_wordDone;
    logic              w_badCount;
    logic              w_lastConv;
    logic              w_lastDense;
    logic [ADDR_W-1:0] w_layersA;
    logic [ADDR_W-1:0] w_idxA;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [ADDR_W-1:0] w_countA;
    logic [ADDR_W-1:0] w_convSpan;
    logic [ADDR_W-1:0] w_denseSpan;

    assign w_reading   = (r_state == RD_HDR) || (r_state == RD_CONV) || (r_state == RD_DENSE);
    assign w_lastWord  = (r_state == RD_HDR) ? (r_word == 2'd3) : (r_word == 2'd1);
    assign w_wordDone  = w_reading && r_phase && w_lastWord;
    assign w_badCount  = (r_layers == '0) || (r_layers > DATA_W'(MAX_LAYERS));
    assign w_lastConv  = (DATA_W'(r_index) + DATA_W'(1)) == r_layers;
    assign w_lastDense = (DATA_W'(r_index) + DATA_W'(2)) == r_layers;
    assign w_layersA   = ADDR_W'(r_layers);
    assign w_idxA      = ADDR_W'(r_index);
    assign w_countA    = ADDR_W'(r_count);
    assign w_convSpan  = ADDR_W'(r_count * r_fs * r_fs);
    assign w_denseSpan = ADDR_W'(r_count * r_type);

    always_ff @(posedge clk) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_rdAddr = '0;
        case (r_state)
            IDLE:       if (start) w_next = RD_HDR;
            RD_HDR: begin
                w_rdAddr = ADDR_W'(r_word);
                if (w_wordDone) w_next = w_badCount ? ERR : RD_CONV;
            end
            RD_CONV: begin
                w_rdAddr = ADDR_W'(4) + w_idxA + (r_word[0] ? w_layersA : '0);
                if (w_wordDone) w_next = CALC;
            end
            RD_DENSE: begin
                // Dense pairs follow the two conv tables: 4 + 2L + 2j (+1 for W)
                w_rdAddr = ADDR_W'(4) + (w_layersA << 1) + (w_idxA << 1) + ADDR_W'(r_word[0]);
                if (w_wordDone) w_next = CALC;
            end
            CALC:       w_next = r_denseMode ? EMIT_DENSE : EMIT_CONV;
            EMIT_CONV:  if (layerReady) w_next = w_lastConv ? CHECK : RD_CONV;
            CHECK: begin
                if (r_ptr != r_denseOff)     w_next = ERR;
                else if (r_layers == 'd1)    w_next = FINISH;
                else                         w_next = RD_DENSE;
            end
            EMIT_DENSE: if (layerReady) w_next = w_lastDense ? FINISH : RD_DENSE;
            FINISH:     w_next = IDLE;
            ERR:        w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_phase     <= 1'b0;
            r_word      <= '0;
            r_index     <= '0;
            r_denseMode <= 1'b0;
            r_fs        <= '0;
            r_layers    <= '0;
            r_denseOff  <= '0;
            r_ptr       <= '0;
            r_count     <= '0;
            r_type      <= '0;
            r_paramBase <= '0;
            r_biasBase  <= '0;
            r_isConv    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_next == ERR) r_error <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_error     <= 1'b0;
                    r_phase     <= 1'b0;
                    r_word      <= '0;
                    r_index     <= '0;
                    r_denseMode <= 1'b0;
                end
                RD_HDR, RD_CONV, RD_DENSE: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_word <= w_lastWord ? 2'd0 : r_word + 2'd1;
                        if (r_state == RD_HDR) begin
                            case (r_word)
                                2'd0:    r_fs       <= ramDataOut;
                                2'd1:    r_layers   <= ramDataOut;
                                2'd2:    r_ptr      <= ADDR_W'(ramDataOut);
                                default: r_denseOff <= ADDR_W'(ramDataOut);
                            endcase
                        end else if (r_word == 2'd0) begin
                            r_count <= ramDataOut;
                        end else begin
                            r_type <= ramDataOut;
                        end
                    end
                end
                CALC: begin
                    r_isConv <= ~r_denseMode;
                    if (r_denseMode) begin
                        r_biasBase  <= r_ptr;
                        r_paramBase <= r_ptr + w_countA;
                        r_ptr       <= r_ptr + w_countA + w_denseSpan;
                    end else begin
                        r_paramBase <= r_ptr;
                        r_biasBase  <= r_ptr + w_convSpan;
                        r_ptr       <= r_ptr + w_convSpan + w_countA;
                    end
                end
                EMIT_CONV:  if (layerReady) r_index <= w_lastConv ? 4'd0 : r_index + 4'd1;
                CHECK:      r_denseMode <= 1'b1;
                EMIT_DENSE: if (layerReady) r_index <= r_index + 4'd1;
                default: ;
            endcase
        end
    end

    assign ramAddress  = (w_reading && !r_phase) ? w_rdAddr : '0;
    assign readSignal  = w_reading && !r_phase;
    assign layerValid  = (r_state == EMIT_CONV) || (r_state == EMIT_DENSE);
    assign layerIsConv = r_isConv;
    assign layerIndex  = r_index;
    assign layerCount  = r_count;
    assign layerType   = r_type;
    assign paramBase   = r_paramBase;
    assign biasBase    = r_biasBase;
    assign filterSize  = r_fs;
    assign busy        = (r_state != IDLE) && (r_state != FINISH) && (r_state != ERR);
    assign done        = (r_state == FINISH) || (r_state == ERR);
    assign error       = r_error;

endmodule
